// File: rtl/psg_length_reg_writer_if.sv
// CPU bus for the length-register front end: single-cycle writes plus a
// registered read port with a one-cycle valid strobe.
interface psg_length_reg_writer_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/psg_length_reg_writer.sv
// Register front end for the four PSG length counters: NRx1/NRx4 storage,
// 256 Hz length clock, level-held trigger bits and a shadow of each counter.
module psg_length_reg_writer #(
    parameter int HALF_PERIOD = 32768,
    parameter int CNT_W       = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    psg_length_reg_writer_if.slave  bus,
    output logic                    clock_256,
    output logic [31:0]             nrx1,
    output logic [31:0]             nrx4,
    output logic [3:0]              ch_active
);
    typedef enum logic [1:0] {IDLE, ARMED, HELD} trig_state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] div_reg;
    logic             clk256_reg;
    logic             div_wrap;
    logic             rise;
    logic             fall;

    assign div_wrap  = (div_reg == DIV_LAST);
    assign rise      = div_wrap & ~clk256_reg;
    assign fall      = div_wrap &  clk256_reg;
    assign clock_256 = clk256_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_reg    <= '0;
            clk256_reg <= 1'b0;
        end else if (div_wrap) begin
            div_reg    <= '0;
            clk256_reg <= ~clk256_reg;
        end else begin
            div_reg    <= div_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            localparam logic [1:0] CH = 2'(gi);

            trig_state_t state_reg;
            logic        trig_reg;
            logic [7:0]  nrx1_reg;
            logic        len_en_reg;
            logic [5:0]  nrx4_lo_reg;
            logic        pend_reg;
            logic [5:0]  cnt_reg;
            logic        wr_nrx1;
            logic        wr_nrx4;

            assign wr_nrx1 = bus.wr_en && (bus.wr_addr == {CH, 1'b0});
            assign wr_nrx4 = bus.wr_en && (bus.wr_addr == {CH, 1'b1});

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg   <= IDLE;
                    trig_reg    <= 1'b0;
                    nrx1_reg    <= '0;
                    len_en_reg  <= 1'b0;
                    nrx4_lo_reg <= '0;
                    pend_reg    <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    // A fresh trigger write always restarts arming; a rise in the
                    // arming cycle itself is ignored because state is still IDLE then.
                    if (wr_nrx4 && bus.wr_data[7]) begin
                        state_reg <= ARMED;
                        trig_reg  <= 1'b1;
                    end else begin
                        case (state_reg)
                            ARMED: if (rise) state_reg <= HELD;
                            HELD: if (fall) begin
                                state_reg <= IDLE;
                                trig_reg  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end

                    if (wr_nrx1) nrx1_reg <= bus.wr_data;
                    if (wr_nrx4) begin
                        len_en_reg  <= bus.wr_data[6];
                        nrx4_lo_reg <= bus.wr_data[5:0];
                    end

                    // Mirrors the length counter: it sees the trigger bit as driven
                    // before this edge, and NRx1=0 wraps to a load of 63.
                    if (rise) begin
                        if (pend_reg || trig_reg)
                            cnt_reg <= nrx1_reg[5:0] - 6'd1;
                        else if (len_en_reg && (cnt_reg != 6'd0))
                            cnt_reg <= cnt_reg - 6'd1;
                    end

                    if ((wr_nrx1 && (bus.wr_data != nrx1_reg)) ||
                        (wr_nrx4 && (bus.wr_data[6] != len_en_reg)))
                        pend_reg <= 1'b1;
                    else if (rise)
                        pend_reg <= 1'b0;
                end
            end

            assign nrx1[8*gi +: 8] = nrx1_reg;
            assign nrx4[8*gi +: 8] = {trig_reg, len_en_reg, nrx4_lo_reg};
            assign ch_active[gi]   = (cnt_reg != 6'd0);
        end
    endgenerate

    logic [4:0] rd_base;
    logic [7:0] rd_mux;

    assign rd_base = {bus.rd_addr[2:1], 3'b000};

    always_comb begin
        rd_mux = 8'h00;
        if (bus.rd_addr[3])
            rd_mux = {4'b0000, ch_active};
        else if (bus.rd_addr[0])
            rd_mux = {1'b1, nrx4[rd_base + 5'd6], 6'b111111};
        else
            rd_mux = nrx1[rd_base +: 8];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.rd_data  <= 8'h00;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) bus.rd_data <= rd_mux;
        end
    end
endmodule

// File: tb/tb_psg_length_reg_writer.sv
// Randomised and directed bench for psg_length_reg_writer against a
// time-indexed reference model of the register front end.
module tb_psg_length_reg_writer;
    localparam int HP = 4;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        clock_256;
    logic [31:0] nrx1;
    logic [31:0] nrx4;
    logic [3:0]  ch_active;

    psg_length_reg_writer_if bus ();

    psg_length_reg_writer #(.HALF_PERIOD(HP), .CNT_W(3)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .clock_256 (clock_256),
        .nrx1      (nrx1),
        .nrx4      (nrx4),
        .ch_active (ch_active)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: k counts clock edges since reset release.
    int         k;
    logic [7:0] m_nrx1 [4];
    logic       m_b6   [4];
    logic [5:0] m_lo   [4];
    logic       m_t7   [4];
    logic       m_seen [4];
    logic       m_pend [4];
    int         m_cnt  [4];
    logic [7:0] m_rd;
    logic       m_rv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_rd = 8'h00;
        m_rv = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_nrx1[c] = 8'h00; m_b6[c] = 1'b0; m_lo[c] = 6'h00;
            m_t7[c] = 1'b0; m_seen[c] = 1'b0; m_pend[c] = 1'b0; m_cnt[c] = 0;
        end
    endtask

    function automatic logic [3:0] active_mask();
        logic [3:0] m = 4'b0000;
        for (int c = 0; c < 4; c++) m[c] = (m_cnt[c] != 0);
        return m;
    endfunction

    task automatic model_step();
        bit         rise = ((k + 1) % (2 * HP)) == HP;
        bit         fall = ((k + 1) % (2 * HP)) == 0;
        logic [3:0] mask = active_mask();
        int         rc;
        m_rv = bus.rd_en;
        if (bus.rd_en) begin
            rc = int'(bus.rd_addr[2:1]);
            if (bus.rd_addr[3])       m_rd = {4'b0000, mask};
            else if (bus.rd_addr[0])  m_rd = {1'b1, m_b6[rc], 6'h3f};
            else                      m_rd = m_nrx1[rc];
        end
        for (int c = 0; c < 4; c++) begin
            bit wr1 = bus.wr_en && (int'(bus.wr_addr[2:1]) == c) && !bus.wr_addr[0];
            bit wr4 = bus.wr_en && (int'(bus.wr_addr[2:1]) == c) &&  bus.wr_addr[0];
            if (rise) begin
                if (m_pend[c] || m_t7[c]) m_cnt[c] = (int'(m_nrx1[c]) % 64 + 63) % 64;
                else if (m_b6[c] && m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
                m_pend[c] = 1'b0;
            end
            if (wr4 && bus.wr_data[7]) begin
                m_t7[c] = 1'b1; m_seen[c] = 1'b0;
            end else if (m_t7[c] && !m_seen[c] && rise) begin
                m_seen[c] = 1'b1;
            end else if (m_seen[c] && fall) begin
                m_t7[c] = 1'b0; m_seen[c] = 1'b0;
            end
            if (wr1) begin
                if (bus.wr_data != m_nrx1[c]) m_pend[c] = 1'b1;
                m_nrx1[c] = bus.wr_data;
            end
            if (wr4) begin
                if (bus.wr_data[6] != m_b6[c]) m_pend[c] = 1'b1;
                m_b6[c] = bus.wr_data[6];
                m_lo[c] = bus.wr_data[5:0];
            end
        end
        k++;
    endtask

    task automatic check_all();
        logic [31:0] e1 = '0;
        logic [31:0] e4 = '0;
        for (int c = 0; c < 4; c++) begin
            e1[8*c +: 8] = m_nrx1[c];
            e4[8*c +: 8] = {m_t7[c], m_b6[c], m_lo[c]};
        end
        check("clock_256", 32'(clock_256), 32'((k / HP) % 2));
        check("nrx1", nrx1, e1);
        check("nrx4", nrx4, e4);
        check("ch_active", 32'(ch_active), 32'(active_mask()));
        check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
        check("rd_data", 32'(bus.rd_data), 32'(m_rd));
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_n) model_step();
        #1;
        check_all();
    endtask

    task automatic write(input logic [2:0] addr, input logic [7:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        int guard;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        model_reset();
        #2 reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        check("reset_outputs", {nrx1[15:0], nrx4[15:0]}, 32'h0);

        // Test 1: divider toggling is checked on every tick.
        repeat (10) tick();

        // Test 2: NRx1=5 then trigger with length enable on ch0.
        write(3'b000, 8'h05);
        write(3'b001, 8'hC0);
        repeat (48) tick();
        check("ch0_trig_released", 32'(nrx4[7]), 32'h0);
        check("ch0_expired", 32'(ch_active[0]), 32'h0);

        // Test 3: trigger written in the same cycle as a rise.
        guard = 0;
        while (((k + 1) % (2 * HP)) != HP && guard < 20) begin tick(); guard++; end
        write(3'b001, 8'hC3);
        check("ch0_armed_at_rise", 32'(nrx4[7]), 32'h1);
        repeat (24) tick();

        // Test 4: identical NRx1 rewrite does not reload, a change does.
        write(3'b100, 8'h05);
        write(3'b101, 8'h40);
        repeat (12) tick();
        write(3'b100, 8'h05);
        repeat (8) tick();
        write(3'b100, 8'h06);
        repeat (40) tick();

        // Test 5: NRx4 readback and status read.
        write(3'b011, 8'h7A);
        bus.rd_en = 1'b1; bus.rd_addr = 4'b0011;
        tick();
        check("rd_nrx4_ch1", 32'(bus.rd_data), 32'hFF);
        check("rd_valid_ch1", 32'(bus.rd_valid), 32'h1);
        bus.rd_addr = 4'b1000;
        tick();
        bus.rd_en = 1'b0;
        tick(); tick();

        // Same-cycle read and write of NRx1 ch0 returns the old byte.
        bus.rd_en = 1'b1; bus.rd_addr = 4'b0000;
        write(3'b000, 8'h3C);
        bus.rd_en = 1'b0;
        check("rd_before_write", 32'(bus.rd_data), 32'h05);
        tick();

        // Test 6: asynchronous reset while ch3 holds its trigger.
        write(3'b111, 8'h80);
        guard = 0;
        while (!m_seen[3] && guard < 40) begin tick(); guard++; end
        check("ch3_reached_held", 32'(m_seen[3]), 32'h1);
        reset_n = 1'b0;
        #1;
        check("ch3_async_drop", 32'(nrx4[31]), 32'h0);
        model_reset();
        check_all();
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 3'($urandom);
            bus.wr_data = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            bus.rd_en   = ($urandom_range(0, 1) == 0);
            bus.rd_addr = 4'($urandom);
            tick();
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/psg_length_reg_writer.md
Name: psg_length_reg_writer

Overview:
CPU-side register front end that drives the NRx1/NRx4 bytes and the 256 Hz length clock into the four per-channel length counters. It converts single-cycle bus writes into the level-held trigger protocol the length counters need. The trigger bit (NRx4[7]) is held high until a 256 Hz rising edge has sampled it, and then released automatically. It also keeps a cycle-exact shadow of each channel's length counter, so that channel-active status can be read back by the CPU.

Parameters:
HALF_PERIOD, 32768, system clocks per half-period of clock_256 (16.78 MHz / 512); minimum 2
CNT_W, 16, divider counter width; must satisfy 2**CNT_W >= HALF_PERIOD

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  single-cycle write strobe
wr_addr  input  3  {ch[1:0], sel}; sel=0 selects NRx1, sel=1 selects NRx4
wr_data  input  8  write data
rd_en  input  1  read strobe
rd_addr  input  4  addr[3]=0 reads a channel register {ch, sel}; addr[3]=1 reads status
rd_data  output  8  read data, registered
rd_valid  output  1  high exactly one cycle after rd_en
clock_256  output  1  registered 256 Hz square wave for the length counters
nrx1  output  32  NRx1 for channel n on bits [8n+7:8n]
nrx4  output  32  NRx4 for channel n on bits [8n+7:8n]
ch_active  output  4  shadow counter != 0, one bit per channel

Behaviour:
- Reset (asynchronous, while reset_n=0) clears the following to 0:
  - divider, clock_256, nrx1, nrx4
  - shadow counters, ch_active
  - all trigger FSMs (to IDLE)
  - rd_data, rd_valid
- Divider:
  - Counts 0..HALF_PERIOD-1.
  - On wrap, clock_256 toggles.
  - rise = cycle in which clock_256 registers 0->1; fall = cycle in which it registers 1->0.
- NRx1 write:
  - Register takes wr_data at the next edge.
  - If wr_data differs from the stored value, set reload_pending[ch].
  - If the value is identical, do not set reload_pending (the counter reloads only on a change).
- NRx4 write:
  - Bit 6 is stored; if the stored bit 6 changes, set reload_pending[ch].
  - Bits 5:0 are stored as written.
  - Bit 7 is owned by the trigger FSM and is never taken directly from wr_data.
- Trigger FSM, one per channel. Output bit nrx4[8ch+7] = (state != IDLE).
  - IDLE: NRx4 write with bit7=1 -> ARMED.
  - ARMED: a rise in a strictly later cycle than the arming write -> HELD. A rise in the same cycle as the write does not count.
  - HELD: fall -> IDLE; bit7 clears at that edge.
  - A new bit7=1 write in ARMED or HELD -> ARMED (restart).
  - A bit7=0 write never cancels a pending trigger.
- Shadow counter, 6 bits per channel, updated only on rise cycles:
  - If reload_pending or (state==HELD or ARMED-qualified): load nrx1[5:0]-1, modulo 64; NRx1=0 loads 63. Then clear reload_pending.
  - Else if bit6=1 and counter != 0: decrement.
  - Else: hold.
  - The trigger condition uses the bit-7 value seen by the length counter at that rise.
  - ch_active is combinational from the counter.
- Read path, one-cycle latency:
  - rd_data/rd_valid update at the edge after rd_en.
  - NRx1 returns the full byte.
  - NRx4 returns {1, bit6, 6'b111111}.
  - Status (addr[3]=1) returns {4'b0000, ch_active}.
  - A read and a write to the same address in the same cycle returns the pre-write value.
  - rd_data holds its value when rd_en=0.
- Reset asserted mid-trigger drops bit7 immediately (asynchronous).

Test Plan:
1. HALF_PERIOD=4, after reset -> clock_256 toggles every 4 clocks; all outputs 0 before the first toggle.
2. Write NRx1(ch0)=0x05, then NRx4(ch0)=0xC0 -> bit7 high until the first fall after a later rise. At that rise the counter loads 4. Decrements to 0 after 4 further rises; ch_active[0] then falls and stays 0.
3. NRx4 write with bit7=1 in the same cycle as a rise -> that rise is ignored; bit7 is released only after the next rise/fall pair.
4. Rewrite NRx1(ch2)=0x05 with an identical value while counting -> no reload. Then write 0x06 -> reload to 5 at the next rise.
5. Read NRx4(ch1) after writing 0x7A -> rd_data=0xFF with rd_valid one cycle later. Read status -> active channels mask, e.g. 0x01.
6. Assert reset_n=0 while ch3 is HELD -> nrx4[31] drops the same cycle; all state is zero after release.
